// File: rtl/ex_muldiv_iter.sv
// Iterative signed/unsigned multiply and divide for the EX stage.
// Processes one operand bit per cycle and stalls the pipeline while busy.
module ex_muldiv_iter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  output logic              stallreq,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo,
  output logic              div_by_zero
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  // MUL: arg = |a|, acc = {partial product, |b|}. DIV: arg = |b|, acc = {remainder, |a| -> quotient}.
  logic [DATA_W-1:0]   arg_q;
  logic [DATA_W-1:0]   acc_hi_q;
  logic [DATA_W-1:0]   acc_lo_q;
  logic                neg_quo_q;
  logic                neg_rem_q;
  logic                done_q;
  logic                div_by_zero_q;
  logic [DATA_W-1:0]   result_hi_q;
  logic [DATA_W-1:0]   result_lo_q;

  logic                is_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] prod_nxt;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W:0]     rem_sh;
  logic                div_ge;
  logic [DATA_W-1:0]   rem_nxt;
  logic [DATA_W-1:0]   quo_nxt;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & src_a[DATA_W-1];
    b_neg     = is_signed & src_b[DATA_W-1];
    mag_a     = a_neg ? -src_a : src_a;
    mag_b     = b_neg ? -src_b : src_b;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, arg_q} : '0);
    prod_nxt  = {mul_sum, acc_lo_q[DATA_W-1:1]};
    prod_fix  = neg_quo_q ? -prod_nxt : prod_nxt;

    // The true difference always fits in DATA_W bits when the trial succeeds.
    rem_sh    = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ge    = rem_sh >= {1'b0, arg_q};
    rem_nxt   = div_ge ? (rem_sh[DATA_W-1:0] - arg_q) : rem_sh[DATA_W-1:0];
    quo_nxt   = {acc_lo_q[DATA_W-2:0], div_ge};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      arg_q         <= '0;
      acc_hi_q      <= '0;
      acc_lo_q      <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      result_hi_q   <= '0;
      result_lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && !cancel) begin
            if (op[1] && (src_b == '0)) begin
              state_q       <= StDone;
              done_q        <= 1'b1;
              div_by_zero_q <= 1'b1;
              result_hi_q   <= src_a;
              result_lo_q   <= '1;
            end else begin
              state_q   <= op[1] ? StDiv : StMul;
              cnt_q     <= CNT_W'(DATA_W);
              arg_q     <= op[1] ? mag_b : mag_a;
              acc_hi_q  <= '0;
              acc_lo_q  <= op[1] ? mag_a : mag_b;
              neg_quo_q <= a_neg ^ b_neg;
              neg_rem_q <= a_neg;
            end
          end
        end
        StMul: begin
          if (cancel) begin
            state_q <= StIdle;
          end else begin
            {acc_hi_q, acc_lo_q} <= prod_nxt;
            cnt_q                <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q       <= StDone;
              done_q        <= 1'b1;
              div_by_zero_q <= 1'b0;
              result_hi_q   <= prod_fix[2*DATA_W-1:DATA_W];
              result_lo_q   <= prod_fix[DATA_W-1:0];
            end
          end
        end
        StDiv: begin
          if (cancel) begin
            state_q <= StIdle;
          end else begin
            acc_hi_q <= rem_nxt;
            acc_lo_q <= quo_nxt;
            cnt_q    <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              state_q       <= StDone;
              done_q        <= 1'b1;
              div_by_zero_q <= 1'b0;
              result_hi_q   <= neg_rem_q ? -rem_nxt : rem_nxt;
              result_lo_q   <= neg_quo_q ? -quo_nxt : quo_nxt;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stallreq    = ((state_q == StIdle) && start && !cancel) ||
                       (state_q == StMul) || (state_q == StDiv);
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  assign result_hi   = result_hi_q;
  assign result_lo   = result_lo_q;

endmodule

// File: tb/tb_ex_muldiv_iter.sv
// Bench for ex_muldiv_iter: directed and random ops against an arithmetic reference,
// plus cancel, reset-abort and an 8-bit instance.
module tb_ex_muldiv_iter;

  localparam int W = 32;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start, cancel;
  logic [1:0]  op;
  logic [31:0] src_a, src_b;
  logic        stallreq, busy, done, div_by_zero;
  logic [31:0] result_hi, result_lo;

  logic        start8, cancel8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        stall8, busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int passes = 0;

  logic [1:0]  r_op;
  logic [31:0] r_a, r_b;
  int          dcount;

  ex_muldiv_iter #(.DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .cancel(cancel), .stallreq(stallreq), .busy(busy), .done(done),
    .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
  );

  ex_muldiv_iter #(.DATA_W(8)) dut8 (
    .clk(clk), .resetn(resetn), .start(start8), .op(op8), .src_a(a8), .src_b(b8),
    .cancel(cancel8), .stallreq(stall8), .busy(busy8), .done(done8),
    .result_hi(hi8), .result_lo(lo8), .div_by_zero(dz8)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero like the unit.
  function automatic void ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint          sa, sb;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    dz = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; {hi, lo} = p; end
      2'b01: begin p = ua * ub; {hi, lo} = p; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = '1; dz = 1'b1;
        end else if (o == 2'b10) begin
          lo = 32'(sa / sb); hi = 32'(sa % sb);
        end else begin
          lo = 32'(ua / ub); hi = 32'(ua % ub);
        end
      end
    endcase
  endfunction

  task automatic run32(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    logic        ez;
    int          n, st, exp_lat;
    ref_op(o, a, b, eh, el, ez);
    exp_lat = ez ? 0 : W;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    #1 check("stall_on_start", 64'(stallreq), 64'(1));
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    n = 0;
    st = 1;
    while (!done && n < 100) begin
      st += int'(stallreq);
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("stall_cycles", 64'(st), 64'(exp_lat + 1));
    check("result_hi", 64'(result_hi), 64'(eh));
    check("result_lo", 64'(result_lo), 64'(el));
    check("div_by_zero", 64'(div_by_zero), 64'(ez));
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_after_done", 64'(busy), 64'(0));
    check("result_held", {result_hi, result_lo}, {eh, el});
  endtask

  task automatic run8(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_res);
    int n;
    @(negedge clk);
    start8 = 1'b1; op8 = o; a8 = a; b8 = b;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w8_latency", 64'(n), 64'(8));
    check("w8_result", 64'({hi8, lo8}), 64'(exp_res));
    check("w8_dz", 64'(dz8), 64'(0));
    @(posedge clk);
    #1 check("w8_idle", 64'({busy8, stall8, done8}), 64'(0));
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    start8 = 1'b0; cancel8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    #12;
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_results", {result_hi, result_lo}, 64'(0));
    check("reset_dz", 64'(div_by_zero), 64'(0));
    check("reset_stall", 64'(stallreq), 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    run32(2'b00, 32'hFFFF_FFFD, 32'd5);
    check("mul_neg3x5", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("mulu_max", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);
    run32(2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_neg7_2", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run32(2'b11, 32'd100, 32'd7);
    check("divu_100_7", {result_hi, result_lo}, {32'd2, 32'd14});
    run32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", {result_hi, result_lo}, 64'h0000_0000_8000_0000);
    run32(2'b11, 32'h0000_1234, 32'd0);
    check("divu_by_zero", {result_hi, result_lo}, 64'h0000_1234_FFFF_FFFF);

    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom);
      r_a  = $urandom;
      r_b  = $urandom;
      case ($urandom_range(0, 4))
        0: r_b = 32'd0;
        1: r_b = 32'($urandom_range(1, 15));
        2: begin r_a = 32'h8000_0000; r_b = '1; end
        default: ;
      endcase
      run32(r_op, r_a, r_b);
    end

    // Cancel mid-MUL: the previous 6*7 result must survive.
    run32(2'b01, 32'd6, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 cancel = 1'b1;
    @(posedge clk);
    #1 cancel = 1'b0;
    check("cancel_idle", 64'(busy), 64'(0));
    check("cancel_results", {result_hi, result_lo}, 64'd42);
    dcount = 0;
    repeat (40) begin
      @(posedge clk);
      #1 dcount += int'(done);
    end
    check("cancel_no_done", 64'(dcount), 64'(0));
    check("cancel_results_kept", {result_hi, result_lo}, 64'd42);

    // start and cancel together in IDLE: nothing starts.
    @(negedge clk);
    start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
    #1 check("start_cancel_stall", 64'(stallreq), 64'(0));
    @(posedge clk);
    #1;
    check("start_cancel_busy", 64'(busy), 64'(0));
    start = 1'b0; cancel = 1'b0;

    // Asynchronous reset mid-DIV.
    run32(2'b11, 32'd100, 32'd7);
    @(negedge clk);
    start = 1'b1; op = 2'b10; src_a = 32'hFFFF_FF9C; src_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 check("busy_before_reset", 64'(busy), 64'(1));
    resetn = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'(0));
    check("async_reset_results", {result_hi, result_lo}, 64'(0));
    check("async_reset_flags", 64'({done, div_by_zero, stallreq}), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    run32(2'b10, 32'hFFFF_FF9C, 32'd3);

    run8(2'b00, 8'hFD, 8'd5, 16'hFFF1);
    run8(2'b10, 8'hF9, 8'd2, 16'hFFFD);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_iter.md
Name: ex_muldiv_iter

Overview:
Parametrised iterative multiply/divide unit for the EX stage. It generalises the single fixed 32-bit multiplier into one shared datapath that handles signed and unsigned MUL and DIV over DATA_W bits. It takes one bit per cycle and returns a 2*DATA_W result as HI/LO. It raises a stall request toward the stall controller while busy, and supports cancel when the pipeline is flushed.

Parameters:
DATA_W, 32, operand width in bits; legal values are even and ≥4.
CNT_W, $clog2(DATA_W)+1, width of the iteration counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
resetn  in  1  asynchronous, active-low reset.
start  in  1  request a new operation; sampled only in IDLE.
op  in  2  operation select: 00 = MUL signed, 01 = MULU, 10 = DIV signed, 11 = DIVU.
src_a  in  DATA_W  multiplicand or dividend.
src_b  in  DATA_W  multiplier or divisor.
cancel  in  1  abort the operation in flight (pipeline flush).
stallreq  out  1  stall request to the stall controller.
busy  out  1  state is not IDLE.
done  out  1  one-cycle pulse; result is valid.
result_hi  out  DATA_W  MUL: upper product half. DIV: remainder.
result_lo  out  DATA_W  MUL: lower product half. DIV: quotient.
div_by_zero  out  1  set with done when a DIV/DIVU had src_b == 0.

Behaviour:
- Reset (resetn low, asynchronous): state = IDLE; counter = 0; result_hi, result_lo, done, div_by_zero, busy = 0. Reset asserted mid-operation aborts it immediately, with no done.
- States: IDLE, MUL, DIV, DONE.
- IDLE → MUL/DIV when start = 1 and cancel = 0.
  - Operands are latched on that edge.
  - For signed ops, the magnitudes of src_a and src_b are latched, along with neg_q = a[MSB] ^ b[MSB] and neg_r = a[MSB].
  - Counter is loaded with DATA_W.
- DIV/DIVU with src_b == 0: IDLE → DONE directly, skipping iteration.
- MUL: shift-add, one multiplier bit per cycle. The 2*DATA_W accumulator is right-shifted each cycle. Counter decrements; when it reaches 1 the next state is DONE.
- DIV: restoring division, one quotient bit per cycle. The remainder is shifted left and the divisor trial-subtracted; the quotient bit is 1 if the difference is ≥ 0. Termination is the same as MUL.
- DONE: lasts exactly one cycle, then → IDLE.
  - done = 1 and the results are registered on entry to DONE.
  - Sign correction is applied at that point: MUL product negated if neg_q; DIV quotient negated if neg_q, remainder negated if neg_r.
- Latency: start accepted at edge N → done high during the cycle after edge N+DATA_W, i.e. DATA_W+1 cycles (33 at the default). Divide-by-zero: done 1 cycle after start.
- Divide by zero: result_hi = src_a, result_lo = all ones, div_by_zero = 1. Otherwise div_by_zero = 0 at done.
- Overflow: signed most-negative / -1 gives quotient = most-negative (wraps), remainder = 0, no flag.
- stallreq (combinational) = (state == IDLE && start && !cancel) || state == MUL || state == DIV. It is deasserted in DONE, so the consuming instruction advances on the done cycle.
- busy = (state != IDLE).
- cancel in MUL/DIV/DONE: next state IDLE. No done pulse; result_hi/lo keep their previous values. cancel and start together in IDLE: cancel wins, no operation starts.
- start while not IDLE: ignored; operands are not relatched.
- result_hi/lo hold their value until the next DONE; they do not clear on return to IDLE.
- op, src_a and src_b may change freely after the accepting edge.

Test Plan:
- DATA_W=32, MUL, a = 0xFFFFFFFD (-3), b = 5 → done exactly 33 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFF1; stallreq high for the cycle start is presented plus 32 cycles.
- MULU, a = b = 0xFFFFFFFF → hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV, a = -7, b = 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU, a = 100, b = 7 → lo = 14, hi = 2. DIV, a = 0x80000000, b = -1 → lo = 0x80000000, hi = 0.
- DIVU, b = 0, a = 0x1234 → done 1 cycle after start; div_by_zero = 1, hi = 0x1234, lo = 0xFFFFFFFF.
- Start MUL; cancel at cycle 10 → IDLE next cycle, no done, previous result unchanged. Start and cancel together in IDLE → no operation starts.
- Reset pulse mid-DIV → all outputs 0 immediately (asynchronous). A new start after reset release completes normally. Repeat the MUL case with DATA_W=8: -3 × 5 → 0xFFF1, latency 9.
